// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- generic inter-stage pipeline register with valid/ready
// handshake and optional 2-entry skid buffer.
//
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   in_valid/in_ready   upstream handshake; in_ctrl/in_data upstream beat
//   flush               sync kill of held and incoming beats (data kept)
//   out_valid/out_ready downstream handshake; out_ctrl masked to 0 when idle,
//                       out_data is the raw head data
//   occupancy           number of held beats (0..2)
//   cnt_clear           sync clear of bubble counter
//   bubble_cnt          saturating count of cycles with out_ready & !out_valid
module pipe_stage_skid #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 96,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              headValid;
  logic [CTRL_W-1:0] headCtrl;
  logic [DATA_W-1:0] headData;
  logic              skidValid;
  logic              inFire;
  logic              outFire;
  logic [CNT_W-1:0]  bubbleCnt;

  assign inFire    = in_valid & in_ready;
  assign outFire   = headValid & out_ready;
  assign out_valid = headValid;
  assign out_ctrl  = headValid ? headCtrl : '0;
  assign out_data  = headData;
  assign occupancy = {1'b0, headValid} + {1'b0, skidValid};

  generate
    if (SKID != 0) begin : gSkid
      logic              skidFull;
      logic [CTRL_W-1:0] skidCtrl;
      logic [DATA_W-1:0] skidData;

      // in_ready depends only on a flop: no comb path from out_ready.
      assign in_ready  = !skidFull;
      assign skidValid = skidFull;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          headValid <= 1'b0;
          headCtrl  <= '0;
          headData  <= '0;
          skidFull  <= 1'b0;
          skidCtrl  <= '0;
          skidData  <= '0;
        end else if (flush) begin
          // Control killed, data kept so restart/exception info survives.
          headValid <= 1'b0;
          headCtrl  <= '0;
          skidFull  <= 1'b0;
          skidCtrl  <= '0;
        end else if (!headValid || outFire) begin
          if (skidFull) begin
            // Skid is older than anything on the input; drain it first.
            headValid <= 1'b1;
            headCtrl  <= skidCtrl;
            headData  <= skidData;
            skidFull  <= 1'b0;
          end else if (inFire) begin
            headValid <= 1'b1;
            headCtrl  <= in_ctrl;
            headData  <= in_data;
          end else begin
            headValid <= 1'b0;
          end
        end else if (inFire) begin
          // Head stalled: park the beat accepted under the registered ready.
          skidFull <= 1'b1;
          skidCtrl <= in_ctrl;
          skidData <= in_data;
        end
      end
    end else begin : gReg
      assign in_ready  = !headValid | out_ready;
      assign skidValid = 1'b0;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          headValid <= 1'b0;
          headCtrl  <= '0;
          headData  <= '0;
        end else if (flush) begin
          headValid <= 1'b0;
          headCtrl  <= '0;
        end else if (inFire) begin
          headValid <= 1'b1;
          headCtrl  <= in_ctrl;
          headData  <= in_data;
        end else if (outFire) begin
          headValid <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                   bubbleCnt <= '0;
    else if (cnt_clear)                           bubbleCnt <= '0;
    else if (out_ready && !headValid && bubbleCnt != CNT_MAX) bubbleCnt <= bubbleCnt + 1'b1;
  end

  assign bubble_cnt = bubbleCnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  typedef struct {
    logic [15:0] ctrl;
    logic [95:0] data;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  // SKID=1 instance, 4-bit counter
  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0, cnt_clear = 0;
  logic [15:0] in_ctrl = 0, out_ctrl;
  logic [95:0] in_data = 0, out_data;
  logic [1:0]  occupancy;
  logic [3:0]  bubble_cnt;

  // SKID=0 instance
  logic        in_valid0 = 0, in_ready0, out_valid0, out_ready0 = 0;
  logic [15:0] in_ctrl0 = 0, out_ctrl0;
  logic [95:0] in_data0 = 0, out_data0;
  logic [1:0]  occupancy0;
  logic [15:0] bubble_cnt0;

  int passCnt = 0;
  int totCnt  = 0;
  beat_t sbq[$];

  always #5 clock = ~clock;

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(96), .SKID(1), .CNT_W(4)) u1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .cnt_clear(cnt_clear), .bubble_cnt(bubble_cnt));

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(96), .SKID(0), .CNT_W(16)) u0 (
    .clock(clock), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_ctrl(in_ctrl0), .in_data(in_data0), .flush(1'b0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occupancy0), .cnt_clear(1'b0), .bubble_cnt(bubble_cnt0));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: score the handshakes of the current cycle, then advance.
  task automatic tick();
    beat_t e;
    bit    doFlush;
    doFlush = flush;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("sb_unexpected_out", {112'd0, out_ctrl}, 128'hx);
      else begin
        e = sbq.pop_front();
        chk("sb_ctrl", {112'd0, out_ctrl}, {112'd0, e.ctrl});
        chk("sb_data", {32'd0, out_data}, {32'd0, e.data});
      end
    end
    if (in_valid && in_ready && !flush) begin
      e.ctrl = in_ctrl;
      e.data = in_data;
      sbq.push_back(e);
    end
    @(posedge clock); #1;
    if (doFlush) sbq.delete();
  endtask

  // Run with out_ready=1 until every scored beat is out; a pending input
  // beat is held until it is accepted.
  task automatic drain(input int maxCyc);
    bit fired;
    int n;
    n = 0;
    out_ready = 1;
    while ((sbq.size() != 0 || in_valid) && n < maxCyc) begin
      fired = in_valid && in_ready;
      tick();
      if (fired) in_valid = 0;
      n++;
    end
    chk("drain_timeout", {127'd0, n < maxCyc}, 128'd1);
  endtask

  initial begin
    // ---- reset state (reset low from time 0) ----
    #2;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_ctrl",  {112'd0, out_ctrl}, 128'd0);
    chk("rst_out_data",  {32'd0, out_data}, 128'd0);
    chk("rst_occupancy", {126'd0, occupancy}, 128'd0);
    chk("rst_in_ready",  {127'd0, in_ready}, 128'd1);
    chk("rst_bubble",    {124'd0, bubble_cnt}, 128'd0);
    chk("rst_in_ready0", {127'd0, in_ready0}, 128'd1);
    @(posedge clock); #1;
    reset = 1;

    // ---- SKID=0: combinational ready, back-to-back ----
    in_valid0 = 1; in_ctrl0 = 16'h7; in_data0 = 96'h77;
    @(posedge clock); #1;
    chk("s0_full_valid",   {127'd0, out_valid0}, 128'd1);
    chk("s0_full_ctrl",    {112'd0, out_ctrl0}, 128'h7);
    chk("s0_full_inready", {127'd0, in_ready0}, 128'd0);
    out_ready0 = 1; in_ctrl0 = 16'h8; in_data0 = 96'h88;
    #1;
    chk("s0_comb_inready", {127'd0, in_ready0}, 128'd1);
    @(posedge clock); #1;
    chk("s0_b2b_ctrl8", {112'd0, out_ctrl0}, 128'h8);
    in_ctrl0 = 16'h9; in_data0 = 96'h99;
    @(posedge clock); #1;
    chk("s0_b2b_valid", {127'd0, out_valid0}, 128'd1);
    chk("s0_b2b_data9", {32'd0, out_data0}, 128'h99);
    in_valid0 = 0;
    @(posedge clock); #1;
    chk("s0_empty_valid", {127'd0, out_valid0}, 128'd0);
    chk("s0_empty_ctrl",  {112'd0, out_ctrl0}, 128'd0);
    chk("s0_empty_data",  {32'd0, out_data0}, 128'h99);
    chk("s0_bubble",      {112'd0, bubble_cnt0}, 128'd0);
    out_ready0 = 0;

    // ---- SKID=1 streaming ----
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_ctrl = 16'(i); in_data = 96'h100 + 96'(i);
      tick();
      chk("stream_occ", {126'd0, occupancy}, 128'd1);
      chk("stream_valid", {127'd0, out_valid}, 128'd1);
    end
    in_valid = 0;
    tick();
    out_ready = 0;
    chk("stream_drained", 128'(sbq.size()), 128'd0);
    chk("stream_bubble", {124'd0, bubble_cnt}, 128'd1);

    // ---- backpressure A,B,C ----
    out_ready = 1; in_valid = 1; in_ctrl = 16'hA; in_data = 96'hA0A;
    tick();
    out_ready = 0; in_ctrl = 16'hB; in_data = 96'hB0B;
    chk("bp_ready_before_b", {127'd0, in_ready}, 128'd1);
    tick();
    in_ctrl = 16'hC; in_data = 96'hC0C;
    for (int k = 0; k < 2; k++) begin
      chk("bp_occ2", {126'd0, occupancy}, 128'd2);
      chk("bp_in_ready0", {127'd0, in_ready}, 128'd0);
      chk("bp_head_a", {112'd0, out_ctrl}, 128'hA);
      tick();
    end
    chk("bp_occ2_end", {126'd0, occupancy}, 128'd2);
    drain(10);
    out_ready = 0;
    chk("bp_occ0", {126'd0, occupancy}, 128'd0);

    // ---- flush at occupancy 2 ----
    out_ready = 1; in_valid = 1; in_ctrl = 16'h1; in_data = 96'hDEAD;
    tick();
    out_ready = 0; in_ctrl = 16'h2; in_data = 96'hBEEF;
    tick();
    in_valid = 0;
    chk("fl_occ2", {126'd0, occupancy}, 128'd2);
    flush = 1;
    tick();
    flush = 0;
    chk("fl_valid", {127'd0, out_valid}, 128'd0);
    chk("fl_ctrl",  {112'd0, out_ctrl}, 128'd0);
    chk("fl_occ",   {126'd0, occupancy}, 128'd0);
    chk("fl_data",  {32'd0, out_data}, 128'hDEAD);

    // ---- flush discards a beat fired in the flush cycle ----
    in_valid = 1; in_ctrl = 16'h3; in_data = 96'h111;
    tick();
    in_ctrl = 16'h4; in_data = 96'h222; flush = 1;
    chk("fl2_ready", {127'd0, in_ready}, 128'd1);
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    chk("fl2_occ",  {126'd0, occupancy}, 128'd0);
    chk("fl2_data", {32'd0, out_data}, 128'h111);
    tick(); tick();
    chk("fl2_no_deliver", {127'd0, out_valid}, 128'd0);

    // ---- bubble counter saturation / clear ----
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    chk("cnt_clear0", {124'd0, bubble_cnt}, 128'd0);
    for (int k = 0; k < 20; k++) tick();
    chk("cnt_sat", {124'd0, bubble_cnt}, 128'd15);
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    chk("cnt_clear_prio", {124'd0, bubble_cnt}, 128'd0);

    // ---- async reset mid-stall ----
    in_valid = 1; in_ctrl = 16'h21; in_data = 96'h2121;
    tick();
    out_ready = 0; in_ctrl = 16'h22; in_data = 96'h2222;
    tick();
    in_valid = 0;
    chk("ar_occ2", {126'd0, occupancy}, 128'd2);
    #3 reset = 0;
    #1;
    sbq.delete();
    chk("ar_valid", {127'd0, out_valid}, 128'd0);
    chk("ar_ctrl",  {112'd0, out_ctrl}, 128'd0);
    chk("ar_data",  {32'd0, out_data}, 128'd0);
    chk("ar_occ",   {126'd0, occupancy}, 128'd0);
    chk("ar_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clock); #1;
    reset = 1;
    in_valid = 1; out_ready = 1; in_ctrl = 16'h55; in_data = 96'h5555;
    tick();
    in_valid = 0;
    chk("ar_first_valid", {127'd0, out_valid}, 128'd1);
    chk("ar_first_ctrl",  {112'd0, out_ctrl}, 128'h55);
    tick();
    chk("ar_drained", 128'(sbq.size()), 128'd0);

    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register that generalises the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the MIPS32 core.
- Replaces hard-coded stall/flush muxing with a valid/ready handshake and an optional 2-entry skid buffer.
- Control bits are cleared on bubbles and flushes. Data bits are held, so restart-PC/exception info survives.
- Includes a bubble performance counter. One instance sits between each pair of adjacent stages.

Parameters:
CTRL_W, 16, width of control field (masked to zero when not valid, cleared on flush)
DATA_W, 96, width of data field (never cleared except by reset)
SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready)
CNT_W, 16, width of saturating bubble counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat this cycle
in_ctrl  input  CTRL_W  upstream control field
in_data  input  DATA_W  upstream data field
flush  input  1  synchronous kill of all held and incoming beats
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts beat
out_ctrl  output  CTRL_W  control field, forced to 0 when out_valid=0
out_data  output  DATA_W  data field of head register (unmasked)
occupancy  output  2  number of held beats (0..2)
cnt_clear  input  1  synchronous clear of bubble counter
bubble_cnt  output  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0

Behaviour:
- Reset (reset=0, async):
  - head_valid, skid_valid = 0.
  - head/skid ctrl and data = 0.
  - bubble_cnt = 0.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 when SKID=1. When SKID=0, in_ready=1 because it is combinational from out_valid=0.
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. out_valid = head_valid.
- Latency and ordering:
  - A beat accepted in cycle N is visible on the outputs in cycle N+1.
  - Throughput is 1 beat/cycle. Order is strictly FIFO.
- SKID=1:
  - in_ready = !skid_valid, registered with no combinational path from out_ready.
  - If head is empty or out_fire, the head loads from skid when skid_valid, else from input when in_fire, else head_valid<=0.
  - If head_valid & !out_ready & in_fire, the beat goes to skid and skid_valid<=1.
  - Skid drains into the head on the next out_fire. A new in_fire in the same cycle refills skid only when the head was empty... not applicable here: in_ready=0 whenever skid is full, so no refill occurs while skid_valid=1.
- SKID=0:
  - in_ready = !head_valid | out_ready.
  - Head loads on in_fire. Otherwise head_valid clears on out_fire. The skid registers are absent.
- Flush (sync, priority over everything except reset):
  - Next cycle: head_valid=0, skid_valid=0, head/skid ctrl=0.
  - head/skid data hold their previous values.
  - An input beat fired in the flush cycle is discarded.
  - in_ready still follows its normal rule during flush.
  - An out_fire in the flush cycle completes normally downstream.
- Ctrl masking: out_ctrl = head_valid ? head_ctrl : 0. A stalled or empty stage therefore presents a NOP downstream.
- occupancy = head_valid + skid_valid.
- bubble_cnt:
  - Increments when out_ready & !out_valid, saturating at 2^CNT_W-1 with no wrap.
  - cnt_clear forces 0 and takes priority over increment.
  - Flush does not affect the counter.
- Simultaneous in_fire and out_fire with occupancy 1: the head is replaced and occupancy stays 1.
- Reset asserted mid-transfer clears immediately (async). Release is synchronous to clock; the first accept can happen in the first clock after release.

Test Plan:
- Streaming, out_ready=1, in_valid=1, SKID=1, ctrl=i, data=0x100+i for i=0..7: outputs match one cycle later, 8 beats in order, occupancy stays 1, bubble_cnt=1 (first cycle only).
- Backpressure: stream beats A,B,C, drop out_ready for 3 cycles after A appears. Required: B captured in skid, occupancy=2, in_ready=0, C held upstream. Raise out_ready: A,B,C delivered in order, none lost or duplicated.
- Flush with occupancy=2, data A=0xDEAD/B=0xBEEF. Next cycle: out_valid=0, out_ctrl=0, occupancy=0, out_data still 0xDEAD. An in_fire in the flush cycle is not delivered.
- SKID=0 build: out_ready=0 with head full gives in_ready=0 in the same cycle. out_ready=1 with in_valid=1 gives a back-to-back transfer with no bubble.
- Counter: hold in_valid=0, out_ready=1 with CNT_W=4 for 20 cycles: bubble_cnt=15 (saturated). Pulse cnt_clear together with the bubble condition: bubble_cnt=0.
- Async reset mid-stall at occupancy=2: outputs zero without a clock edge. After release, the first beat passes with 1-cycle latency.
